// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: FU result packet, CDB broadcast packet and sizing constants.
// Both packets carry the same payload fields; the CDB one replaces done with valid.
package cdb_arbiter_pkg;

    localparam int unsigned ROB_TAG_W      = 5;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned NUM_FU_DEFAULT = 4;

    typedef struct packed {
        logic                 done;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      v;
        logic                 take_branch;
        logic [XLEN-1:0]      branch_loc;
        logic                 mispredicted;
        logic [XLEN-1:0]      origin_PC;
        logic                 cond_br_en;
        logic                 br_en;
    } FU_OUT_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      v;
        logic                 take_branch;
        logic [XLEN-1:0]      branch_loc;
        logic                 mispredicted;
        logic [XLEN-1:0]      origin_PC;
        logic                 cond_br_en;
        logic                 br_en;
    } CDB_PACKET;

    // Bit-exact field copy of a winning FU result into a valid CDB broadcast.
    function automatic CDB_PACKET to_cdb(input FU_OUT_PACKET f);
        CDB_PACKET c;
        c.valid        = 1'b1;
        c.rob_tag      = f.rob_tag;
        c.v            = f.v;
        c.take_branch  = f.take_branch;
        c.branch_loc   = f.branch_loc;
        c.mispredicted = f.mispredicted;
        c.origin_PC    = f.origin_PC;
        c.cond_br_en   = f.cond_br_en;
        c.br_en        = f.br_en;
        return c;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to ptr-1.
module cdb_arbiter_rr_select #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned idx;
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_grant && req[idx[IW-1:0]]) begin
                any_grant               = 1'b1;
                grant_idx               = idx[IW-1:0];
                grant[idx[IW-1:0]]      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one FU result per cycle onto the registered CDB.
// Squash flushes every pending result and resets the priority pointer.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = NUM_FU_DEFAULT,
    localparam int unsigned PTR_W = $clog2(NUM_FU)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash,
    input  FU_OUT_PACKET       fu_out_packet [NUM_FU],
    output logic [NUM_FU-1:0]  fu_ack,
    output CDB_PACKET          cdb_packet,
    output logic [PTR_W-1:0]   rr_ptr_dbg
);

    logic [NUM_FU-1:0] done_vec;
    logic [NUM_FU-1:0] grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              any_grant;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    CDB_PACKET         cdb_q, cdb_d;

    always_comb begin
        done_vec = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            done_vec[i] = fu_out_packet[i].done;
        end
    end

    cdb_arbiter_rr_select #(
        .N (NUM_FU)
    ) u_rr_select (
        .req       (done_vec),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Squash acks every pending result so the FUs drop them; reset masks everything.
    always_comb begin
        if (reset) begin
            fu_ack = '0;
        end else if (squash) begin
            fu_ack = done_vec;
        end else begin
            fu_ack = grant;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        cdb_d    = '0;
        if (squash) begin
            rr_ptr_d = '0;
        end else if (any_grant) begin
            cdb_d    = to_cdb(fu_out_packet[grant_idx]);
            rr_ptr_d = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
            cdb_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

    assign cdb_packet = cdb_q;
    assign rr_ptr_dbg = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus random traffic against a
// behavioural round-robin model; a separate monitor checks every CDB broadcast.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = $clog2(N);

    logic             clock = 1'b0;
    logic             reset;
    logic             squash;
    FU_OUT_PACKET     fu_pkt [N];
    logic [N-1:0]     fu_ack;
    CDB_PACKET        cdb_packet;
    logic [PW-1:0]    rr_ptr_dbg;

    int               checks = 0;
    int               fails  = 0;
    CDB_PACKET        exp_q[$];
    int               model_ptr = 0;
    bit               mon_en = 1'b0;
    logic [N-1:0]     ack_seen;
    int               cnt [N];

    always #5 clock = ~clock;

    cdb_arbiter #(
        .NUM_FU (N)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .squash        (squash),
        .fu_out_packet (fu_pkt),
        .fu_ack        (fu_ack),
        .cdb_packet    (cdb_packet),
        .rr_ptr_dbg    (rr_ptr_dbg)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: first done index scanning upward from the pointer with wrap-around.
    function automatic int pick_winner(input logic [N-1:0] d, input int p);
        for (int k = 0; k < int'(N); k++) begin
            if (d[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < int'(N); i++) begin
            fu_pkt[i].rob_tag      = ROB_TAG_W'($urandom);
            fu_pkt[i].v            = $urandom;
            fu_pkt[i].take_branch  = 1'($urandom);
            fu_pkt[i].branch_loc   = $urandom;
            fu_pkt[i].mispredicted = 1'($urandom);
            fu_pkt[i].origin_PC    = $urandom;
            fu_pkt[i].cond_br_en   = 1'($urandom);
            fu_pkt[i].br_en        = 1'($urandom);
        end
    endtask

    // Called just after a negedge; drives one cycle and returns at the next negedge.
    task automatic cycle(input logic rst, input logic sq, input logic [N-1:0] done);
        int           w;
        logic [N-1:0] exp_ack;
        CDB_PACKET    e;
        reset  = rst;
        squash = sq;
        for (int i = 0; i < int'(N); i++) fu_pkt[i].done = done[i];
        #1;
        w = pick_winner(done, model_ptr);
        if (rst)          exp_ack = '0;
        else if (sq)      exp_ack = done;
        else if (w >= 0)  exp_ack = N'(1) << w;
        else              exp_ack = '0;
        ack_seen = fu_ack;
        chk("fu_ack", 128'(fu_ack), 128'(exp_ack));
        if (rst || sq) begin
            model_ptr = 0;
        end else if (w >= 0) begin
            e              = '0;
            e.valid        = 1'b1;
            e.rob_tag      = fu_pkt[w].rob_tag;
            e.v            = fu_pkt[w].v;
            e.take_branch  = fu_pkt[w].take_branch;
            e.branch_loc   = fu_pkt[w].branch_loc;
            e.mispredicted = fu_pkt[w].mispredicted;
            e.origin_PC    = fu_pkt[w].origin_PC;
            e.cond_br_en   = fu_pkt[w].cond_br_en;
            e.br_en        = fu_pkt[w].br_en;
            exp_q.push_back(e);
            model_ptr = (w + 1) % N;
        end
        @(negedge clock);
        chk("rr_ptr", 128'(rr_ptr_dbg), 128'(model_ptr));
    endtask

    // Monitor: every broadcast must match the oldest expected result; idle CDB must be zero.
    initial begin
        CDB_PACKET e;
        forever begin
            @(posedge clock);
            #1;
            if (mon_en) begin
                if (cdb_packet.valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL cdb_unexpected: actual valid=1 required no broadcast");
                    end else begin
                        e = exp_q.pop_front();
                        chk("cdb_packet", 128'(cdb_packet), 128'(e));
                    end
                end else begin
                    chk("cdb_idle", 128'(cdb_packet), 128'(0));
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        squash = 1'b0;
        rand_fields();
        for (int i = 0; i < int'(N); i++) fu_pkt[i].done = 1'b0;
        @(negedge clock);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, '1);
        mon_en = 1'b1;

        // Single request
        fu_pkt[2].rob_tag = 5'd5;
        fu_pkt[2].v       = 32'h1234;
        cycle(1'b0, 1'b0, 4'b0100);
        chk("single_ack", 128'(ack_seen), 128'(4'b0100));
        chk("single_ptr", 128'(rr_ptr_dbg), 128'(3));
        chk("single_valid", 128'(cdb_packet.valid), 128'(1));
        chk("single_tag", 128'(cdb_packet.rob_tag), 128'(5));
        chk("single_v", 128'(cdb_packet.v), 128'(32'h1234));

        // Wrap-around from pointer 3
        cycle(1'b0, 1'b0, 4'b0011);
        chk("wrap_ack0", 128'(ack_seen), 128'(4'b0001));
        chk("wrap_ptr1", 128'(rr_ptr_dbg), 128'(1));
        cycle(1'b0, 1'b0, 4'b0011);
        chk("wrap_ack1", 128'(ack_seen), 128'(4'b0010));
        chk("wrap_ptr2", 128'(rr_ptr_dbg), 128'(2));

        // Squash flush-all
        cycle(1'b0, 1'b1, 4'b1010);
        chk("squash_ack", 128'(ack_seen), 128'(4'b1010));
        chk("squash_valid", 128'(cdb_packet.valid), 128'(0));
        chk("squash_ptr", 128'(rr_ptr_dbg), 128'(0));

        // Branch pass-through
        fu_pkt[1].take_branch  = 1'b1;
        fu_pkt[1].mispredicted = 1'b1;
        fu_pkt[1].branch_loc   = 32'h80;
        cycle(1'b0, 1'b0, 4'b0010);
        chk("br_take", 128'(cdb_packet.take_branch), 128'(1));
        chk("br_misp", 128'(cdb_packet.mispredicted), 128'(1));
        chk("br_loc", 128'(cdb_packet.branch_loc), 128'(32'h80));

        // Reset mid-operation with pointer at 2
        chk("rst_pre_ptr", 128'(rr_ptr_dbg), 128'(2));
        cycle(1'b1, 1'b0, 4'b1111);
        chk("rst_ack", 128'(ack_seen), 128'(0));
        chk("rst_valid", 128'(cdb_packet.valid), 128'(0));
        chk("rst_ptr", 128'(rr_ptr_dbg), 128'(0));
        cycle(1'b0, 1'b0, 4'b1111);
        chk("rst_after_ack", 128'(ack_seen), 128'(4'b0001));

        // Fairness: all done held for 8 cycles from reset
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < int'(N); i++) cnt[i] = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 4'b1111);
            chk("fair_order", 128'(ack_seen), 128'(N'(1) << (k % N)));
            for (int i = 0; i < int'(N); i++) if (ack_seen[i]) cnt[i]++;
        end
        for (int i = 0; i < int'(N); i++) chk("fair_count", 128'(cnt[i]), 128'(2));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            rand_fields();
            r = int'($urandom_range(0, 39));
            cycle(r == 0, (r >= 1) && (r <= 4), N'($urandom));
        end

        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        chk("sb_drain", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
